// File: rtl/aidc_lite_bdi_pkg.sv
// Shared types and constants for the AIDC-Lite BDI decompressor lane.
// Optional mode 5 (32-bit deltas) is enabled by defining AIDC_LITE_DECOMP_BDI_DELTA4_EN.
package aidc_lite_bdi_pkg;

    localparam int unsigned BLK_ENTRIES = 16;

    typedef enum logic [3:0] {
        ModeRaw  = 4'd0,
        ModeZero = 4'd1,
        ModeRep  = 4'd2,
        ModeB8d1 = 4'd3,
        ModeB8d2 = 4'd4,
        ModeB8d4 = 4'd5
    } bdi_mode_e;

    // Packet lengths in 32-bit words, header included.
    localparam logic [5:0] LEN_RAW  = 6'd33;
    localparam logic [5:0] LEN_ZERO = 6'd1;
    localparam logic [5:0] LEN_REP  = 6'd3;
    localparam logic [5:0] LEN_B8D1 = 6'd7;
    localparam logic [5:0] LEN_B8D2 = 6'd11;
    localparam logic [5:0] LEN_B8D4 = 6'd19;

`ifdef AIDC_LITE_DECOMP_BDI_DELTA4_EN
    localparam int unsigned DELTA_WIDTH = 512;
`else
    localparam int unsigned DELTA_WIDTH = 256;
`endif
    localparam int unsigned DELTA_WORDS = DELTA_WIDTH / 32;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRecv = 2'd1;
    localparam logic [1:0] StEmit = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    function automatic logic mode_legal(input logic [3:0] mode);
        case (mode)
            ModeRaw, ModeZero, ModeRep, ModeB8d1, ModeB8d2: mode_legal = 1'b1;
`ifdef AIDC_LITE_DECOMP_BDI_DELTA4_EN
            ModeB8d4: mode_legal = 1'b1;
`endif
            default: mode_legal = 1'b0;
        endcase
    endfunction

    // Index of the word that must carry eop for a well-formed packet.
    function automatic logic [5:0] mode_last(input logic [3:0] mode);
        case (mode)
            ModeRaw:  mode_last = LEN_RAW - 6'd1;
            ModeZero: mode_last = LEN_ZERO - 6'd1;
            ModeRep:  mode_last = LEN_REP - 6'd1;
            ModeB8d1: mode_last = LEN_B8D1 - 6'd1;
            ModeB8d2: mode_last = LEN_B8D2 - 6'd1;
            ModeB8d4: mode_last = LEN_B8D4 - 6'd1;
            default:  mode_last = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/aidc_lite_bdi_delta_unit.sv
// Reconstructs one block entry: base plus the sign-extended delta selected by mode and index.
// Mode 5 is only decoded when AIDC_LITE_DECOMP_BDI_DELTA4_EN is defined.
module aidc_lite_bdi_delta_unit
    import aidc_lite_bdi_pkg::*;
(
    input  logic [3:0]             mode,
    input  logic [63:0]            base,
    input  logic [DELTA_WIDTH-1:0] deltas,
    input  logic [3:0]             idx,
    output logic [63:0]            entry
);

    logic [7:0]  d8;
    logic [15:0] d16;
`ifdef AIDC_LITE_DECOMP_BDI_DELTA4_EN
    logic [31:0] d32;
`endif

    always_comb begin
        d8  = deltas[{idx, 3'b000} +: 8];
        d16 = deltas[{idx, 4'b0000} +: 16];
`ifdef AIDC_LITE_DECOMP_BDI_DELTA4_EN
        d32 = deltas[{idx, 5'b00000} +: 32];
`endif
        entry = '0;
        case (mode)
            ModeRep:  entry = base;
            ModeB8d1: entry = base + {{56{d8[7]}}, d8};
            ModeB8d2: entry = base + {{48{d16[15]}}, d16};
`ifdef AIDC_LITE_DECOMP_BDI_DELTA4_EN
            ModeB8d4: entry = base + {{32{d32[31]}}, d32};
`endif
            default:  entry = '0;
        endcase
    end

endmodule

// File: rtl/aidc_lite_decomp_bdi.sv
// AIDC-Lite base-delta-immediate decoder: packet of 32-bit words in, sixteen 64-bit buffer writes out.
// Define AIDC_LITE_DECOMP_BDI_DELTA4_EN to accept mode 5 (32-bit deltas).
module aidc_lite_decomp_bdi
    import aidc_lite_bdi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  sop_i,
    input  logic                  eop_i,
    input  logic [31:0]           data_i,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [63:0]           data_o,
    output logic                  done_o,
    output logic                  err_o
);

    logic [1:0]             state_q, state_d;
    logic [3:0]             mode_q, mode_d;
    logic [5:0]             cnt_q, cnt_d;
    logic [63:0]            base_q, base_d;
    logic [DELTA_WIDTH-1:0] delta_q, delta_d;
    logic [3:0]             idx_q, idx_d;
    logic                   err_q, err_d;
    logic                   raw_wr_q, raw_wr_d;
    logic [3:0]             raw_addr_q, raw_addr_d;
    logic [63:0]            raw_data_q, raw_data_d;
    logic [63:0]            entry;
    logic                   restart;
    logic                   bad_word;

    assign restart = valid_i && sop_i;

    aidc_lite_bdi_delta_unit u_delta (
        .mode   (mode_q),
        .base   (base_q),
        .deltas (delta_q),
        .idx    (idx_q),
        .entry  (entry)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        delta_d    = delta_q;
        idx_d      = idx_q;
        err_d      = err_q;
        raw_wr_d   = 1'b0;
        raw_addr_d = raw_addr_q;
        raw_data_d = raw_data_q;
        bad_word   = 1'b0;

        if (restart) begin
            mode_d = data_i[3:0];
            cnt_d  = 6'd1;
            idx_d  = '0;
            err_d  = 1'b0;
            if (!mode_legal(data_i[3:0])) begin
                state_d = StDone;
                err_d   = 1'b1;
            end else if (eop_i) begin
                if (data_i[3:0] == ModeZero) begin
                    state_d = StEmit;
                end else begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end
            end else begin
                state_d = StRecv;
            end
        end else begin
            unique case (state_q)
                StRecv: begin
                    if (valid_i) begin
                        cnt_d    = cnt_q + 6'd1;
                        bad_word = eop_i ? (cnt_q != mode_last(mode_q))
                                         : (cnt_q > mode_last(mode_q));
                        if (bad_word) begin
                            state_d = StDone;
                            err_d   = 1'b1;
                        end else begin
                            if (mode_q == ModeRaw) begin
                                // Odd words are low halves; the even word completes a pair.
                                if (cnt_q[0]) begin
                                    base_d[31:0] = data_i;
                                end else begin
                                    raw_wr_d   = 1'b1;
                                    raw_addr_d = cnt_q[4:1] - 4'd1;
                                    raw_data_d = {data_i, base_q[31:0]};
                                end
                            end else if (cnt_q == 6'd1) begin
                                base_d[31:0] = data_i;
                            end else if (cnt_q == 6'd2) begin
                                base_d[63:32] = data_i;
                            end else begin
                                for (int s = 0; s < DELTA_WORDS; s++) begin
                                    if (cnt_q == 6'(s + 3)) delta_d[s*32 +: 32] = data_i;
                                end
                            end
                            if (eop_i) state_d = (mode_q == ModeRaw) ? StDone : StEmit;
                        end
                    end
                end
                StEmit: begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'(BLK_ENTRIES - 1)) state_d = StDone;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= '0;
            cnt_q      <= '0;
            base_q     <= '0;
            delta_q    <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            raw_wr_q   <= 1'b0;
            raw_addr_q <= '0;
            raw_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            delta_q    <= delta_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            raw_wr_q   <= raw_wr_d;
            raw_addr_q <= raw_addr_d;
            raw_data_q <= raw_data_d;
        end
    end

    // A new header cancels emission in its own cycle; an already-latched RAW pair still lands.
    always_comb begin
        valid_o = 1'b0;
        addr_o  = '0;
        data_o  = '0;
        if (!rst) begin
            if (raw_wr_q) begin
                valid_o = 1'b1;
                addr_o  = raw_addr_q;
                data_o  = raw_data_q;
            end else if (state_q == StEmit && !restart) begin
                valid_o = 1'b1;
                addr_o  = idx_q;
                data_o  = entry;
            end
        end
    end

    assign done_o = !rst && !restart && (state_q == StDone) && !raw_wr_q;
    assign err_o  = done_o && err_q;

endmodule

// File: doc/aidc_lite_decomp_bdi.md
Name: aidc_lite_decomp_bdi

Overview:
- Third decompressor lane of the AIDC-Lite decompression path: a base-delta-immediate (BDI) decoder.
- Input: the engine's 32-bit compressed-word stream on the decomp2 write-enable lane.
- Output: one 128-byte block as sixteen 64-bit writes into the shared 16-entry block buffer.
- The buffer write port is OR-combined with the SR and ZRLE decoders, so every output is zero whenever this block is not writing.

Parameters:
- ADDR_WIDTH, 4, buffer address width; the block is 2**ADDR_WIDTH 64-bit entries. Only 4 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  input word strobe (engine decomp2 write enable)
- sop_i  in  1  first word of a packet; qualified by valid_i
- eop_i  in  1  last word of a packet; qualified by valid_i
- data_i  in  32  compressed word
- valid_o  out  1  buffer write enable
- addr_o  out  4  buffer write address; 0 when valid_o=0
- data_o  out  64  buffer write data; 0 when valid_o=0
- done_o  out  1  level; block fully written (or aborted on error)
- err_o  out  1  level; malformed packet, valid while done_o=1

Behaviour:
- One clock domain; clk and rst with synchronous, active-high reset. While rst=1, all state returns to IDLE and all outputs are 0, including mid-packet.
- Packet format:
  - word0 is the header: mode=[3:0], bits [31:4] ignored.
  - Every 64-bit value is carried as two words, low word first.
  - Deltas are packed little-endian: element k sits in the lowest-order position of the packed stream.
- Modes and expected packet length in words (header included):
  - 0 RAW: 33 words, 16 values.
  - 1 ZERO: 1 word.
  - 2 REP: 3 words, one value written to all 16 entries.
  - 3 B8D1: 7 words, 64-bit base followed by 16 signed 8-bit deltas.
  - 4 B8D2: 11 words, base followed by 16 signed 16-bit deltas.
  - Any other mode is illegal.
- Reconstruction: entry[i] = base + sign_extend(delta[i]), modulo 2^64.
- State machine IDLE -> RECV -> EMIT -> DONE:
  - IDLE: valid_i&sop_i captures the header and goes to RECV. If eop_i is set in the same cycle, go to EMIT for mode 1, else DONE with err_o=1. Words arriving without sop_i are ignored.
  - RECV: a 6-bit word counter stores base and deltas into registers (256-bit delta store).
    - RAW writes on the fly: each second word of a pair produces valid_o in the next cycle, addr = pair index.
    - eop_i on exactly the expected word: RAW goes to DONE one cycle after its final write; other modes go to EMIT.
    - eop_i early, or a word beyond the expected count without eop_i: go to DONE with err_o=1 and no further writes.
  - EMIT: 16 consecutive cycles of valid_o=1, addr 0..15 ascending. The first write is the cycle after the eop word.
  - DONE: done_o=1 the cycle after the last write and held until the next valid_i&sop_i. err_o is held with it.
- valid_i&sop_i in any state restarts decoding with that word as a new header. done_o and err_o clear in that cycle, and any in-progress emission is abandoned.
- The engine supplies no backpressure. Input is accepted every cycle; at most one write is issued per cycle.
- err_o=1 implies no further writes after the point of detection. RAW writes already issued are not retracted.

Optional Feature:
- Macro AIDC_LITE_DECOMP_BDI_DELTA4_EN.
- When defined: mode 5 B8D4 is legal, 19 words (base followed by 16 signed 32-bit deltas). The delta store widens to 512 bits.
- When undefined: mode 5 is illegal and handled like any other illegal mode (DONE, err_o=1).

Decomposition:
- Shared package aidc_lite_bdi_pkg holds:
  - mode enum;
  - expected-length constants per mode;
  - state enum;
  - BLK_ENTRIES=16.
- One sub-module, aidc_lite_bdi_delta_unit: combinational mode-select, sign-extend and 64-bit add for entry index i.

Test Plan:
- RAW, words 0..32 = {0, i}, one per cycle -> 16 writes, entry k = {2k+2, 2k+1}, each one cycle after its word pair; done_o=1 one cycle after addr 15.
- ZERO, single word with sop=eop=1 -> writes 0 to addr 0..15 on cycles 1..16; done_o on cycle 17; err_o=0.
- B8D1, base 0x0000_0001_FFFF_FFF0, deltas 0x10, 0x80 (-128), 0x7F -> entries 0x0000_0002_0000_0000, 0x0000_0001_FFFF_FF70, 0x0000_0002_0000_006F.
- B8D2 with eop on word 9 (early) -> no writes, done_o=1, err_o=1. Illegal mode 7 -> same response.
- Restart: sop mid-EMIT of a REP packet, followed by a ZERO packet -> REP writes stop; 16 zero writes; done_o low until the new completion; idle outputs are exactly 0.
- rst=1 during RAW RECV, then a ZERO packet -> outputs 0 during reset; the ZERO packet decodes normally.
